// File: rtl/pipeline_pkg.sv
// Shared types and widths for the pipeline hazard/stall control slice.
package pipeline_pkg;
  localparam int REG_IDX_W   = 4;
  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// SRAM wait-state sequencer: freezes the pipeline for MEM_LATENCY cycles per access,
// then flags data valid for one cycle; the still-high mem_req in DONE never retriggers.
module mem_wait_fsm
  import pipeline_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic mem_freeze,
  output logic mem_start,
  output logic mem_done
);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  mem_state_t r_state;
  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_cnt   <= LAT_M1;
            r_state <= (MEM_LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Start is gated by rst so a request held through reset does not pulse early.
  assign mem_start  = ~rst & (r_state == IDLE) & mem_req;
  assign mem_freeze = mem_start | (~rst & (r_state == BUSY));
  assign mem_done   = ~rst & (r_state == DONE);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: RAW hazard detect, taken-branch flush, SRAM freeze.
// Controls are combinational from current inputs and FSM state; stall_count saturates.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter bit FWD_EN      = 1'b1,
  parameter int CNT_W       = STALL_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_src1,
  input  logic                 id_src1_valid,
  input  logic [REG_IDX_W-1:0] id_src2,
  input  logic                 id_two_src,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_wb_en,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic                 mem_wb_en,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 stat_clr,
  output logic                 stall_front,
  output logic                 flush_if_id,
  output logic                 bubble_id_ex,
  output logic                 mem_freeze,
  output logic                 mem_start,
  output logic                 mem_done,
  output logic [CNT_W-1:0]     stall_count
);
  logic w_m1, w_m2, w_m3, w_m4, w_hz, w_freeze;
  logic w_stall_front, w_flush_if_id, w_bubble_id_ex;
  logic [CNT_W-1:0] r_stall_count;

  mem_wait_fsm #(.MEM_LATENCY(MEM_LATENCY)) u_mem_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_freeze (w_freeze),
    .mem_start  (mem_start),
    .mem_done   (mem_done)
  );

  assign w_m1 = id_src1_valid & ex_wb_en  & (ex_rd  == id_src1);
  assign w_m2 = id_two_src    & ex_wb_en  & (ex_rd  == id_src2);
  assign w_m3 = id_src1_valid & mem_wb_en & (mem_rd == id_src1);
  assign w_m4 = id_two_src    & mem_wb_en & (mem_rd == id_src2);

  // With forwarding only a load in EX cannot be bypassed in time.
  assign w_hz = FWD_EN ? (ex_mem_read & (w_m1 | w_m2)) : (w_m1 | w_m2 | w_m3 | w_m4);

  // A freeze holds a taken branch in ID/EX, so its flush simply waits for the thaw.
  always_comb begin
    w_stall_front  = 1'b0;
    w_flush_if_id  = 1'b0;
    w_bubble_id_ex = 1'b0;
    if (!rst) begin
      if (w_freeze) begin
        w_stall_front = 1'b1;
      end else if (ex_branch_taken) begin
        w_flush_if_id  = 1'b1;
        w_bubble_id_ex = 1'b1;
      end else if (w_hz) begin
        w_stall_front  = 1'b1;
        w_bubble_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (stat_clr) begin
      r_stall_count <= '0;
    end else if (w_stall_front && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_front  = w_stall_front;
  assign flush_if_id  = w_flush_if_id;
  assign bubble_id_ex = w_bubble_id_ex;
  assign mem_freeze   = w_freeze;
  assign stall_count  = r_stall_count;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: two instances (latency 4 with forwarding, latency 1 without forwarding and a
// 3-bit counter) checked against a cycle-level reference model of the controller rules.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_src1, id_src2, ex_rd, mem_rd;
  logic id_src1_valid, id_two_src, ex_wb_en, ex_mem_read, mem_wb_en;
  logic ex_branch_taken, mem_req, stat_clr;

  logic a_sf, a_fl, a_bub, a_frz, a_st, a_dn;
  logic [31:0] a_cnt;
  logic b_sf, b_fl, b_bub, b_frz, b_st, b_dn;
  logic [2:0] b_cnt;

  typedef struct packed {logic sf, fl, bub, frz, st, dn;} ctl_t;

  int checks = 0;
  int failures = 0;

  // Reference model state: freeze cycles still owed, data-valid flag, counters.
  int a_left, b_left;
  bit a_done, b_done;
  longint a_cnt_m, b_cnt_m;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_LATENCY(4), .FWD_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src1_valid(id_src1_valid),
    .id_src2(id_src2), .id_two_src(id_two_src), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_wb_en(mem_wb_en),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .stat_clr(stat_clr),
    .stall_front(a_sf), .flush_if_id(a_fl), .bubble_id_ex(a_bub), .mem_freeze(a_frz),
    .mem_start(a_st), .mem_done(a_dn), .stall_count(a_cnt));

  pipeline_hazard_ctrl #(.MEM_LATENCY(1), .FWD_EN(1'b0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src1_valid(id_src1_valid),
    .id_src2(id_src2), .id_two_src(id_two_src), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_wb_en(mem_wb_en),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .stat_clr(stat_clr),
    .stall_front(b_sf), .flush_if_id(b_fl), .bubble_id_ex(b_bub), .mem_freeze(b_frz),
    .mem_start(b_st), .mem_done(b_dn), .stall_count(b_cnt));

  function automatic ctl_t got_a();
    ctl_t g = {a_sf, a_fl, a_bub, a_frz, a_st, a_dn};
    return g;
  endfunction

  function automatic ctl_t got_b();
    ctl_t g = {b_sf, b_fl, b_bub, b_frz, b_st, b_dn};
    return g;
  endfunction

  function automatic ctl_t model(input bit fwd, input int left, input bit dflag);
    ctl_t e = '0;
    bit m1, m2, m3, m4, hz;
    if (rst) return e;
    m1 = id_src1_valid && ex_wb_en && (ex_rd == id_src1);
    m2 = id_two_src && ex_wb_en && (ex_rd == id_src2);
    m3 = id_src1_valid && mem_wb_en && (mem_rd == id_src1);
    m4 = id_two_src && mem_wb_en && (mem_rd == id_src2);
    hz = fwd ? (ex_mem_read && (m1 || m2)) : (m1 || m2 || m3 || m4);
    e.st  = !dflag && (left == 0) && mem_req;
    e.frz = e.st || (left > 0);
    e.dn  = dflag;
    if (e.frz) e.sf = 1'b1;
    else if (ex_branch_taken) begin e.fl = 1'b1; e.bub = 1'b1; end
    else if (hz) begin e.sf = 1'b1; e.bub = 1'b1; end
    return e;
  endfunction

  task automatic upd(input ctl_t e, input int lat, input longint maxc,
                     inout int left, inout bit dflag, inout longint cnt);
    if (rst) begin
      left = 0; dflag = 1'b0; cnt = 0;
    end else begin
      if (e.st) begin
        left = lat - 1; dflag = (lat == 1);
      end else if (left > 0) begin
        left--; dflag = (left == 0);
      end else begin
        dflag = 1'b0;
      end
      if (stat_clr) cnt = 0;
      else if (e.sf && cnt < maxc) cnt = cnt + 1;
    end
  endtask

  task automatic advance();
    ctl_t ea, eb;
    ea = model(1'b1, a_left, a_done);
    eb = model(1'b0, b_left, b_done);
    @(posedge clk);
    upd(ea, 4, 64'hFFFF_FFFF, a_left, a_done, a_cnt_m);
    upd(eb, 1, 7, b_left, b_done, b_cnt_m);
    @(negedge clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) begin
      a_left = 0; a_done = 1'b0; a_cnt_m = 0;
      b_left = 0; b_done = 1'b0; b_cnt_m = 0;
    end
  endtask

  task automatic clear_inputs();
    id_src1 = 4'd0; id_src2 = 4'd0; ex_rd = 4'd0; mem_rd = 4'd0;
    id_src1_valid = 1'b0; id_two_src = 1'b0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
    mem_wb_en = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_rst(1'b1);
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (got_a() !== 6'b0 || got_b() !== 6'b0) begin
      failures++; $display("FAIL reset_ctl a=%b b=%b expected 000000", got_a(), got_b());
    end
    advance();
    checks++;
    if (a_cnt !== 32'd0 || b_cnt !== 3'd0 || a_dn !== 1'b0) begin
      failures++; $display("FAIL reset_cnt a=%0d b=%0d done=%b expected 0", a_cnt, b_cnt, a_dn);
    end
    clear_inputs();
    set_rst(1'b0);
    advance();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_rd = 4'd3; id_src1 = 4'd3; id_src1_valid = 1'b1;
    #1;
    checks++;
    if (got_a() !== 6'b101000 || got_b() !== 6'b101000) begin
      failures++; $display("FAIL load_use a=%b b=%b expected 101000", got_a(), got_b());
    end
    ex_mem_read = 1'b0;
    #1;
    checks++;
    if (got_a() !== 6'b000000 || got_b() !== 6'b101000) begin
      failures++; $display("FAIL non_load a=%b expected 000000 b=%b expected 101000", got_a(), got_b());
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_no_forwarding();
    mem_wb_en = 1'b1; mem_rd = 4'd5; id_two_src = 1'b1; id_src2 = 4'd5;
    #1;
    checks++;
    if (got_b() !== 6'b101000 || got_a() !== 6'b000000) begin
      failures++; $display("FAIL no_fwd b=%b expected 101000 a=%b expected 000000", got_b(), got_a());
    end
    mem_rd = 4'd6;
    #1;
    checks++;
    if (got_b() !== 6'b000000) begin
      failures++; $display("FAIL no_fwd_miss b=%b expected 000000", got_b());
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    ctl_t ea, eb;
    longint base = a_cnt_m;
    mem_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      ea = '{sf: (k != 4), fl: 1'b0, bub: 1'b0, frz: (k != 4), st: (k == 0 || k == 5), dn: (k == 4)};
      eb = '{sf: (k % 2 == 0), fl: 1'b0, bub: 1'b0, frz: (k % 2 == 0), st: (k % 2 == 0), dn: (k % 2 == 1)};
      checks++;
      if (got_a() !== ea) begin
        failures++; $display("FAIL mem_wait_lat4 cycle %0d got=%b expected=%b", k, got_a(), ea);
      end
      checks++;
      if (got_b() !== eb) begin
        failures++; $display("FAIL mem_wait_lat1 cycle %0d got=%b expected=%b", k, got_b(), eb);
      end
      if (k == 4) begin
        checks++;
        if (a_cnt !== 32'(base + 4)) begin
          failures++; $display("FAIL mem_wait_count got=%0d expected=%0d", a_cnt, base + 4);
        end
      end
      advance();
    end
    mem_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (got_a() !== model(1'b1, a_left, a_done) || got_b() !== model(1'b0, b_left, b_done)) begin
        failures++; $display("FAIL mem_drain cycle %0d a=%b b=%b", k, got_a(), got_b());
      end
      advance();
    end
  endtask

  task automatic test_branch_freeze();
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ctl_t ea;
      if (k == 5) begin mem_req = 1'b0; ex_branch_taken = 1'b0; end
      #1;
      ea = '{sf: (k < 4), fl: (k == 4), bub: (k == 4), frz: (k < 4), st: (k == 0), dn: (k == 4)};
      checks++;
      if (got_a() !== ea) begin
        failures++; $display("FAIL branch_freeze cycle %0d got=%b expected=%b", k, got_a(), ea);
      end
      checks++;
      if (got_b() !== model(1'b0, b_left, b_done)) begin
        failures++; $display("FAIL branch_freeze_b cycle %0d got=%b expected=%b", k, got_b(), model(1'b0, b_left, b_done));
      end
      advance();
    end
  endtask

  task automatic test_branch_load_use();
    clear_inputs();
    ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_rd = 4'd7; id_src2 = 4'd7; id_two_src = 1'b1;
    #1;
    checks++;
    if (got_a() !== 6'b011000 || got_b() !== 6'b011000) begin
      failures++; $display("FAIL branch_load_use a=%b b=%b expected 011000", got_a(), got_b());
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    mem_req = 1'b1;
    advance();
    advance();
    ex_branch_taken = 1'b1;
    set_rst(1'b1);
    #1;
    checks++;
    if (got_a() !== 6'b0 || a_cnt !== 32'd0) begin
      failures++; $display("FAIL rst_busy ctl=%b cnt=%0d expected 0", got_a(), a_cnt);
    end
    advance();
    set_rst(1'b0);
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (got_a() !== 6'b0) begin
        failures++; $display("FAIL rst_busy_no_done cycle %0d got=%b expected 000000", k, got_a());
      end
      advance();
    end
    mem_req = 1'b1;
    #1;
    checks++;
    if (a_st !== 1'b1 || a_frz !== 1'b1) begin
      failures++; $display("FAIL rst_busy_restart start=%b freeze=%b expected 1 1", a_st, a_frz);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 1) mem_req = 1'b0;
      advance();
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    stat_clr = 1'b1;
    advance();
    checks++;
    if (b_cnt !== 3'd0 || a_cnt !== 32'd0) begin
      failures++; $display("FAIL stat_clr b=%0d a=%0d expected 0", b_cnt, a_cnt);
    end
    stat_clr = 1'b0;
    mem_wb_en = 1'b1; mem_rd = 4'd9; id_src1 = 4'd9; id_src1_valid = 1'b1;
    for (int k = 0; k < 6; k++) advance();
    checks++;
    if (b_cnt !== 3'd6) begin
      failures++; $display("FAIL sat_preload got=%0d expected 6", b_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      advance();
      checks++;
      if (b_cnt !== 3'd7) begin
        failures++; $display("FAIL sat_hold step %0d got=%0d expected 7", k, b_cnt);
      end
    end
    stat_clr = 1'b1;
    advance();
    checks++;
    if (b_cnt !== 3'd0) begin
      failures++; $display("FAIL sat_clr_priority got=%0d expected 0", b_cnt);
    end
    clear_inputs();
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
      ex_rd = 4'($urandom_range(0, 3)); mem_rd = 4'($urandom_range(0, 3));
      id_src1_valid = 1'($urandom_range(0, 1)); id_two_src = 1'($urandom_range(0, 1));
      ex_wb_en = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
      mem_wb_en = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 99) < 20);
      mem_req = ($urandom_range(0, 99) < 35);
      stat_clr = ($urandom_range(0, 99) < 3);
      set_rst($urandom_range(0, 99) < 3);
      #1;
      checks++;
      if (got_a() !== model(1'b1, a_left, a_done) || a_cnt !== a_cnt_m[31:0]) begin
        failures++; $display("FAIL rand_a iter %0d ctl=%b expected=%b cnt=%0d expected=%0d",
                             n, got_a(), model(1'b1, a_left, a_done), a_cnt, a_cnt_m);
      end
      checks++;
      if (got_b() !== model(1'b0, b_left, b_done) || b_cnt !== b_cnt_m[2:0]) begin
        failures++; $display("FAIL rand_b iter %0d ctl=%b expected=%b cnt=%0d expected=%0d",
                             n, got_b(), model(1'b0, b_left, b_done), b_cnt, b_cnt_m);
      end
      checks++;
      if ((a_st && a_dn) || (b_st && b_dn)) begin
        failures++; $display("FAIL start_done_overlap iter %0d a=%b%b b=%b%b expected not both", n, a_st, a_dn, b_st, b_dn);
      end
      advance();
    end
    set_rst(1'b0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_forwarding();
    test_mem_wait();
    test_branch_freeze();
    test_branch_load_use();
    test_reset_mid_busy();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
